div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
Multi-cycle sequencer for RV32M DIV/DIVU/REM/REMU, invoked by the execute stage.
- Latches operands, runs a 32-iteration radix-2 restoring division, applies sign correction and returns the result with a one-cycle ready pulse.
- Drives the execute-stage stall request while a division is in flight.
- Honours pipeline flush.

Parameters:
DATA_W, 32, operand/result width; only 32 is supported
CNT_W, 5, iteration counter width, log2(DATA_W)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start_i  in  1  execute stage holds a division instruction (level, held while stalled)
funct3_i  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU
dividend_i  in  32  rs1 value
divisor_i  in  32  rs2 value
reg_waddr_i  in  5  destination register
flush_i  in  1  pipeline flush; abort any operation
result_o  out  32  quotient or remainder; valid when ready_o=1
ready_o  out  1  one-cycle completion pulse
reg_waddr_o  out  5  destination register latched at start
busy_o  out  1  state != IDLE
stallreq_o  out  1  to the pipeline controller, combinational

Behaviour:
- Reset (rst_n=0, async): state=IDLE, result_o=0, ready_o=0, reg_waddr_o=0, busy_o=0, counter=0, internal operand registers=0.
- States: IDLE, CALC, FIN.
- IDLE:
  - If start_i=1, funct3_i[2]=1 and flush_i=0, latch operands, funct3 and waddr.
  - Divisor==0 -> FIN with quotient=32'hFFFFFFFF, remainder=dividend.
  - Signed op with dividend==32'h80000000 and divisor==32'hFFFFFFFF -> FIN with quotient=32'h80000000, remainder=0.
  - Otherwise -> CALC with counter=0.
  - Signed ops convert both operands to magnitudes and record sign_q = sign(a)^sign(b) and sign_r = sign(a).
- CALC:
  - One step per cycle: rem = {rem[30:0], dvd[31]}, dvd <<= 1.
  - If rem >= divisor, rem -= divisor and shift 1 into the quotient LSB; else shift 0.
  - Counter increments each cycle; after the step with counter==31 -> FIN. CALC lasts exactly 32 cycles.
  - start_i is ignored in CALC; operands are not re-sampled.
- FIN:
  - result_o is registered. For signed ops, quotient is negated if sign_q and remainder is negated if sign_r (skipped for the special cases, which are already final).
  - Selection: funct3_i[1]=0 -> quotient, 1 -> remainder.
  - ready_o=1 for exactly this cycle; next state IDLE. start_i is ignored in FIN.
- Latency: start accepted in cycle N -> ready_o in N+33 (normal) or N+1 (special case).
- stallreq_o = (state==IDLE & start_i & funct3_i[2] & !flush_i) | (state==CALC).
  - stallreq_o is low in FIN so the execute stage advances on the same cycle the result is presented.
- result_o and reg_waddr_o hold their value after FIN until the next FIN or reset.
- A start_i present in the cycle after FIN is a new instruction and is accepted normally (back-to-back divisions).
- flush_i=1 in any state -> IDLE next cycle, counter=0, no ready_o pulse, result_o unchanged. Flush has priority over start.
- start_i with funct3_i[2]=0 (MUL group) is ignored: no stall, stays IDLE.
- Async reset mid-CALC clears everything; no ready_o is produced.

Decomposition:
- define.v gains:
  - `INST_DIV 3'b100, `INST_DIVU 3'b101, `INST_REM 3'b110, `INST_REMU 3'b111.
  - State encodings `DIV_IDLE 2'b00, `DIV_CALC 2'b01, `DIV_FIN 2'b10.
- One optional combinational sub-module div_step: a single restoring iteration (rem_in, dvd_msb, divisor -> rem_out, q_bit), kept separate for unit testing.
- The execute stage muxes result_o into reg_data_o on ready_o.

Test Plan:
- DIVU 100/7: start with funct3=101, a=32'd100, b=32'd7 -> stallreq_o high for 33 cycles, ready_o at N+33, result_o=32'd14; REMU (111) on the same operands -> 32'd2.
- Signed DIV -7/2: a=32'hFFFFFFF9, b=2 -> quotient 32'hFFFFFFFD; REM -> 32'hFFFFFFFF (sign follows dividend).
- Divide by zero: DIV a=5, b=0 -> ready_o at N+1, result_o=32'hFFFFFFFF; REM a=5, b=0 -> 32'd5.
- Overflow: DIV a=32'h80000000, b=32'hFFFFFFFF -> 32'h80000000 at N+1; REM on the same operands -> 0.
- Flush at CALC cycle 10 -> state IDLE next cycle, no ready_o, stallreq_o low, result_o keeps its previous value.
- Back-to-back: DIVU 10/3 then DIVU 9/3 with start_i held -> two ready pulses with results 3 and 3, the second 34 cycles after the first.
- Async reset asserted mid-CALC -> all outputs 0 immediately, no ready_o.

Source files
------------

// File: rtl/div_seq_pkg.sv
// Shared types, opcode constants and helpers for the RV32M division sequencer.
package div_seq_pkg;

  localparam int DIV_W = 32;

  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_CALC = 2'b01,
    DIV_FIN  = 2'b10
  } div_state_e;

  function automatic logic [DIV_W-1:0] cond_neg(input logic neg, input logic [DIV_W-1:0] val);
    return neg ? (~val + 1'b1) : val;
  endfunction

endpackage

// File: rtl/div_seq_step.sv
// One radix-2 restoring division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_in,
  input  logic              dvd_msb,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_out,
  output logic              q_bit
);

  // The shifted partial remainder can reach 2*divisor-1, so compare on DATA_W+1 bits.
  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  assign shifted = {rem_in, dvd_msb};
  assign diff    = shifted - {1'b0, divisor};
  assign q_bit   = (shifted >= {1'b0, divisor});
  assign rem_out = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer for the execute stage, with stall request and flush.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DATA_W = DIV_W,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [2:0]        funct3_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  input  logic [4:0]        reg_waddr_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] result_o,
  output logic              ready_o,
  output logic [4:0]        reg_waddr_o,
  output logic              busy_o,
  output logic              stallreq_o
);

  div_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] dvd;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] divisor_r;
  logic              sign_q;
  logic              sign_r;
  logic              rem_sel;
  logic [4:0]        waddr_q;

  logic              accept;
  logic              signed_op;
  logic              a_neg;
  logic              b_neg;
  logic              div_zero;
  logic              overflow;
  logic [DATA_W-1:0] step_rem;
  logic              step_q;
  logic [DATA_W-1:0] fin_q;
  logic [DATA_W-1:0] fin_r;

  assign accept    = start_i & funct3_i[2] & ~flush_i;
  assign signed_op = ~funct3_i[0];
  assign a_neg     = signed_op & dividend_i[DATA_W-1];
  assign b_neg     = signed_op & divisor_i[DATA_W-1];
  assign div_zero  = (divisor_i == '0);
  assign overflow  = signed_op & (dividend_i == {1'b1, {(DATA_W-1){1'b0}}})
                                & (divisor_i == {DATA_W{1'b1}});

  assign busy_o     = (state != DIV_IDLE);
  assign stallreq_o = ((state == DIV_IDLE) & accept) | (state == DIV_CALC);

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem_in  (rem),
    .dvd_msb (dvd[DATA_W-1]),
    .divisor (divisor_r),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // The dividend register doubles as the quotient: bits shift out the top as quotient bits shift in.
  assign fin_q = cond_neg(sign_q, {dvd[DATA_W-2:0], step_q});
  assign fin_r = cond_neg(sign_r, step_rem);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= DIV_IDLE;
      cnt         <= '0;
      dvd         <= '0;
      rem         <= '0;
      divisor_r   <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      rem_sel     <= 1'b0;
      waddr_q     <= '0;
      result_o    <= '0;
      ready_o     <= 1'b0;
      reg_waddr_o <= '0;
    end else if (flush_i) begin
      state   <= DIV_IDLE;
      cnt     <= '0;
      ready_o <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          ready_o <= 1'b0;
          if (accept) begin
            waddr_q   <= reg_waddr_i;
            rem_sel   <= funct3_i[1];
            sign_q    <= a_neg ^ b_neg;
            sign_r    <= a_neg;
            dvd       <= cond_neg(a_neg, dividend_i);
            divisor_r <= cond_neg(b_neg, divisor_i);
            rem       <= '0;
            cnt       <= '0;
            // Special cases bypass the iteration and are already in final form.
            if (div_zero) begin
              result_o    <= funct3_i[1] ? dividend_i : {DATA_W{1'b1}};
              reg_waddr_o <= reg_waddr_i;
              ready_o     <= 1'b1;
              state       <= DIV_FIN;
            end else if (overflow) begin
              result_o    <= funct3_i[1] ? '0 : {1'b1, {(DATA_W-1){1'b0}}};
              reg_waddr_o <= reg_waddr_i;
              ready_o     <= 1'b1;
              state       <= DIV_FIN;
            end else begin
              state <= DIV_CALC;
            end
          end
        end
        DIV_CALC: begin
          rem <= step_rem;
          dvd <= {dvd[DATA_W-2:0], step_q};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) begin
            result_o    <= rem_sel ? fin_r : fin_q;
            reg_waddr_o <= waddr_q;
            ready_o     <= 1'b1;
            state       <= DIV_FIN;
          end
        end
        DIV_FIN: begin
          ready_o <= 1'b0;
          state   <= DIV_IDLE;
        end
        default: begin
          ready_o <= 1'b0;
          state   <= DIV_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: directed vectors push expectations, a monitor checks each ready pulse.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  reg_waddr_i;
  logic        flush_i;
  logic [31:0] result_o;
  logic        ready_o;
  logic [4:0]  reg_waddr_o;
  logic        busy_o;
  logic        stallreq_o;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  waddr;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [31:0] last_res;

  div_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .funct3_i    (funct3_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .reg_waddr_i (reg_waddr_i),
    .flush_i     (flush_i),
    .result_o    (result_o),
    .ready_o     (ready_o),
    .reg_waddr_o (reg_waddr_o),
    .busy_o      (busy_o),
    .stallreq_o  (stallreq_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && ready_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_ready: got result %h expected no pulse (cycle %0d)", result_o, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("result", result_o, e.res);
        checkOutput("waddr", 32'(reg_waddr_o), 32'(e.waddr));
        checkOutput("ready_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Drives one instruction and holds start_i while the stall is requested.
  // delay=1 when issued during the FIN cycle of the previous division.
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] wa, input logic [31:0] exp_res,
                               input bit special, input int delay, input bit hold);
    int  count;
    bit  done;
    exp_t e;
    start_i     = 1'b1;
    funct3_i    = f3;
    dividend_i  = a;
    divisor_i   = b;
    reg_waddr_i = wa;
    e.res   = exp_res;
    e.waddr = wa;
    e.cyc   = cyc + delay + (special ? 1 : 33);
    sb.push_back(e);
    last_res = exp_res;
    count = 0;
    done  = 1'b0;
    for (int k = 0; k < 80 && !done; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (stallreq_o) count++;
      else if (count > 0) done = 1'b1;
    end
    checkOutput("stall_cycles", 32'(count), special ? 32'd1 : 32'd33);
    if (!hold) begin
      start_i = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    start_i     = 1'b0;
    funct3_i    = 3'b000;
    dividend_i  = '0;
    divisor_i   = '0;
    reg_waddr_i = '0;
    flush_i     = 1'b0;
    last_res    = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_result", result_o, 32'd0);
    checkOutput("rst_ready", 32'(ready_o), 32'd0);
    checkOutput("rst_waddr", 32'(reg_waddr_o), 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // MUL group must be ignored
    start_i  = 1'b1;
    funct3_i = 3'b000;
    #1;
    checkOutput("mul_stall", 32'(stallreq_o), 32'd0);
    @(negedge clk);
    checkOutput("mul_busy", 32'(busy_o), 32'd0);
    start_i = 1'b0;
    @(negedge clk);

    applyStimulus(3'b101, 32'd100, 32'd7, 5'd1, 32'd14, 1'b0, 0, 1'b0);
    applyStimulus(3'b111, 32'd100, 32'd7, 5'd2, 32'd2, 1'b0, 0, 1'b0);
    applyStimulus(3'b100, 32'hFFFFFFF9, 32'd2, 5'd3, 32'hFFFFFFFD, 1'b0, 0, 1'b0);
    applyStimulus(3'b110, 32'hFFFFFFF9, 32'd2, 5'd4, 32'hFFFFFFFF, 1'b0, 0, 1'b0);
    applyStimulus(3'b100, 32'd7, 32'hFFFFFFFE, 5'd5, 32'hFFFFFFFD, 1'b0, 0, 1'b0);
    applyStimulus(3'b110, 32'd7, 32'hFFFFFFFE, 5'd6, 32'd1, 1'b0, 0, 1'b0);
    applyStimulus(3'b100, 32'h80000000, 32'd2, 5'd7, 32'hC0000000, 1'b0, 0, 1'b0);
    applyStimulus(3'b101, 32'hFFFFFFFF, 32'h80000001, 5'd8, 32'd1, 1'b0, 0, 1'b0);
    applyStimulus(3'b111, 32'hFFFFFFFF, 32'h80000001, 5'd9, 32'h7FFFFFFE, 1'b0, 0, 1'b0);
    applyStimulus(3'b100, 32'd5, 32'd0, 5'd10, 32'hFFFFFFFF, 1'b1, 0, 1'b0);
    applyStimulus(3'b110, 32'd5, 32'd0, 5'd11, 32'd5, 1'b1, 0, 1'b0);
    applyStimulus(3'b110, 32'hFFFFFFF9, 32'd0, 5'd12, 32'hFFFFFFF9, 1'b1, 0, 1'b0);
    applyStimulus(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 1'b1, 0, 1'b0);
    applyStimulus(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0, 1'b1, 0, 1'b0);

    // Back-to-back with start_i held across FIN
    applyStimulus(3'b101, 32'd10, 32'd3, 5'd15, 32'd3, 1'b0, 0, 1'b1);
    applyStimulus(3'b101, 32'd9, 32'd3, 5'd16, 32'd3, 1'b0, 1, 1'b0);

    // Flush during CALC cycle 10, then flush competing with start in IDLE
    start_i     = 1'b1;
    funct3_i    = 3'b101;
    dividend_i  = 32'd1000;
    divisor_i   = 32'd3;
    reg_waddr_i = 5'd20;
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("flush_busy", 32'(busy_o), 32'd0);
    checkOutput("flush_stall", 32'(stallreq_o), 32'd0);
    checkOutput("flush_result", result_o, last_res);
    start_i = 1'b1;
    #1;
    checkOutput("flush_prio_stall", 32'(stallreq_o), 32'd0);
    @(negedge clk);
    flush_i = 1'b0;
    start_i = 1'b0;
    checkOutput("flush_prio_busy", 32'(busy_o), 32'd0);
    repeat (40) @(negedge clk);
    checkOutput("flush_hold_result", result_o, last_res);
    checkOutput("flush_hold_waddr", 32'(reg_waddr_o), 32'd16);

    // Async reset in the middle of CALC
    start_i    = 1'b1;
    funct3_i   = 3'b101;
    dividend_i = 32'd50;
    divisor_i  = 32'd5;
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_result", result_o, 32'd0);
    checkOutput("arst_waddr", 32'(reg_waddr_o), 32'd0);
    checkOutput("arst_busy", 32'(busy_o), 32'd0);
    checkOutput("arst_ready", 32'(ready_o), 32'd0);
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("arst_idle_busy", 32'(busy_o), 32'd0);

    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
